// File: rtl/pcie_tl_pkg.sv
// Shared encodings for the transaction-layer VC path: link states, VC count,
// destination field layout and the arbiter's pause-tracking states.
package pcie_tl_pkg;

   localparam int NUM_VC = 4;

   // Destination index is the top DEST_W bits of every word.
   localparam int DEST_W = 2;

   typedef enum logic [3:0] {
      ST_RESET  = 4'b0001,
      ST_INIT   = 4'b0010,
      ST_IDLE   = 4'b0100,
      ST_ACTIVE = 4'b1000
   } link_state_e;

   typedef enum logic {
      PS_RUN  = 1'b0,
      PS_HOLD = 1'b1
   } pause_state_e;

   function automatic logic [NUM_VC-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
      logic [NUM_VC-1:0] oh;
      oh       = '0;
      oh[dest] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority encoder: first asserted req at or after ptr, wrapping mod 4.
module rr_pick4
   import pcie_tl_pkg::*;
(
   input  logic [NUM_VC-1:0] req,
   input  logic [1:0]        ptr,
   output logic [NUM_VC-1:0] gnt,
   output logic [1:0]        gnt_idx
);

   logic       found;
   logic [1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = ptr;
      found   = 1'b0;
      idx     = ptr;
      for (int k = 0; k < NUM_VC; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Round-robin VC arbiter: moves one word per cycle from a non-empty input FIFO
// to the output FIFO named by its destination field, throttled by hysteresis.
//
//   pause FSM state | meaning
//   PS_RUN          | arbitration allowed (when link is ACTIVE)
//   PS_HOLD         | an output FIFO hit the high-water mark; wait for low-water
module vc_rr_arbiter
   import pcie_tl_pkg::*;
#(
   parameter int DATA_W = 6,
   parameter int CNT_W  = 3
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               State,
   input  logic [CNT_W-1:0]         umbral_superior,
   input  logic [CNT_W-1:0]         umbral_inferior,
   input  logic [NUM_VC-1:0]        empty_in,
   input  logic [NUM_VC*DATA_W-1:0] data_in,
   input  logic [NUM_VC*CNT_W-1:0]  out_count,
   output logic [NUM_VC-1:0]        pop,
   output logic [NUM_VC-1:0]        push,
   output logic [DATA_W-1:0]        data_out,
   output logic                     pause,
   output logic [1:0]               grant_ptr
);

   pause_state_e ps_q, ps_d;

   logic [DATA_W-1:0] word  [NUM_VC];
   logic [CNT_W-1:0]  count [NUM_VC];

   logic [NUM_VC-1:0] gnt;
   logic [1:0]        gnt_idx;
   logic              arb_en;
   logic              any_grant;
   logic [DATA_W-1:0] sel_word;
   logic [DEST_W-1:0] sel_dest;
   logic              any_hi;
   logic              all_lo;

   for (genvar i = 0; i < NUM_VC; i++) begin : g_unpack
      assign word[i]  = data_in[i*DATA_W +: DATA_W];
      assign count[i] = out_count[i*CNT_W +: CNT_W];
   end

   rr_pick4 u_pick (
      .req     (~empty_in),
      .ptr     (grant_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // pop is combinational, so it must be gated by reset directly rather than
   // relying on the registered state.
   assign arb_en    = reset && (State == ST_ACTIVE) && (ps_q == PS_RUN);
   assign pop       = arb_en ? gnt : '0;
   assign any_grant = |pop;
   assign sel_word  = word[gnt_idx];
   assign sel_dest  = sel_word[DATA_W-1 -: DEST_W];
   assign pause     = (ps_q == PS_HOLD);

   always_comb begin
      any_hi = 1'b0;
      all_lo = 1'b1;
      for (int j = 0; j < NUM_VC; j++) begin
         if (count[j] >= umbral_superior) any_hi = 1'b1;
         if (count[j] >  umbral_inferior) all_lo = 1'b0;
      end
   end

   always_comb begin
      ps_d = ps_q;
      case (ps_q)
         PS_RUN:  if (any_hi) ps_d = PS_HOLD;
         PS_HOLD: if (all_lo) ps_d = PS_RUN;
         default: ps_d = PS_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_q <= PS_RUN;
      end else begin
         ps_q <= ps_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         push      <= '0;
         data_out  <= '0;
         grant_ptr <= '0;
      end else if (any_grant) begin
         push      <= dest_onehot(sel_dest);
         data_out  <= sel_word;
         grant_ptr <= gnt_idx + 2'd1;
      end else begin
         push      <= '0;
      end
   end

endmodule

// File: doc/vc_rr_arbiter.md
Name: vc_rr_arbiter

Overview:
- Sits downstream of the link state machine: consumes its 4-bit one-hot State and the latched threshold pair (umbral_superior/umbral_inferior), plus the empty flags and show-ahead data of the four input VC FIFOs.
- Round-robin arbitrates one word per cycle from a non-empty input FIFO, routes it by its destination field into one of four output FIFOs, and throttles with hysteresis on output-FIFO occupancy.

Parameters:
- DATA_W, 6, word width; bits [DATA_W-1:DATA_W-2] are the destination index 0..3.
- CNT_W, 3, width of output-FIFO occupancy counts and of the threshold inputs.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- State  input  4  one-hot link state: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
- umbral_superior  input  CNT_W  pause threshold (high-water mark).
- umbral_inferior  input  CNT_W  resume threshold (low-water mark).
- empty_in  input  4  empty flag of input FIFO i (bit i).
- data_in  input  4*DATA_W  show-ahead read data; FIFO i occupies [i*DATA_W +: DATA_W]; valid whenever empty_in[i]=0.
- out_count  input  4*CNT_W  occupancy of output FIFO j, [j*CNT_W +: CNT_W].
- pop  output  4  one-hot or zero read strobe to input FIFOs (combinational).
- push  output  4  one-hot or zero write strobe to output FIFOs (registered).
- data_out  output  DATA_W  word written with push (registered).
- pause  output  1  hysteresis throttle flag (registered).
- grant_ptr  output  2  current round-robin priority pointer (registered).

Behaviour:
- Reset (reset=0, asynchronous): push=0, data_out=0, pause=0, grant_ptr=0. pop is forced to 0 while reset is low.
- Arbitration is enabled only when State==ACTIVE and pause==0. Any other State value, including non-one-hot, disables it.
- Eligible input i: empty_in[i]==0.
- Search order: grant_ptr, grant_ptr+1, ... mod 4. The first eligible input wins and pop[i]=1 in the same cycle.
- On a grant to input i:
  - grant_ptr <= (i+1) mod 4.
  - data_out <= data_in[i].
  - push[dest] <= 1, where dest = data_in[i][DATA_W-1:DATA_W-2].
- Latency: pop in cycle N gives push/data_out in cycle N+1.
- With no grant: push <= 0, data_out holds its value, grant_ptr holds.
- Pause hysteresis, evaluated every cycle from the current inputs and registered:
  - If pause==0 and any out_count[j] >= umbral_superior, then pause <= 1.
  - If pause==1 and all out_count[j] <= umbral_inferior, then pause <= 0.
  - Otherwise pause holds.
  - All comparisons are unsigned CNT_W-bit.
- umbral_superior==0 forces pause high from the cycle after ACTIVE is entered. That is legal: it is how software disables traffic.
- umbral_inferior >= umbral_superior is legal. The block then releases as soon as the counts drop to the low-water level, with no additional protection.
- Pause is evaluated in every State, so it is valid when ACTIVE is entered.
- Pause asserts in cycle N+1 when the threshold is crossed in cycle N. A grant made in cycle N still completes: push fires in N+1. Output FIFOs must therefore tolerate one word of slack above umbral_superior.
- State leaving ACTIVE in cycle N: no pop in N. A push already scheduled from N-1 still occurs in N.
- Reset asserted mid-transfer: a pending push is discarded, and the word popped in the previous cycle is lost by design.
- Single input eligible repeatedly: it is granted every cycle. Back-to-back pops are permitted because show-ahead data updates combinationally after each pop.

Decomposition:
- Shared package (pcie_tl_pkg):
  - State encodings RESET/INIT/IDLE/ACTIVE; these must match the state machine exactly.
  - NUM_VC=4.
  - Destination field position constants.
- Sub-module rr_pick4: a purely combinational rotate-priority encoder. Inputs are req[3:0] and ptr[1:0]; outputs are gnt[3:0] and gnt_idx[1:0].
- The top module holds the pointer, pause, push and data registers.

Test Plan:
- Reset/idle: reset low with State=ACTIVE and all FIFOs non-empty, then reset released with State=IDLE. Required: pop=0, push=0, pause=0, grant_ptr=0 throughout.
- Round-robin:
  - Setup: State=ACTIVE, thresholds 6/2, all out_count=0, all four inputs non-empty.
  - Words: input0=6'b00_0001, input1=6'b01_0010, input2=6'b10_0011, input3=6'b11_0100.
  - Required: pop sequence 0001,0010,0100,1000,0001. Push sequence one cycle later 0001,0010,0100,1000 with data_out equal to the matching word. grant_ptr sequence 1,2,3,0.
- Skip empty: inputs 1 and 2 empty, grant_ptr=1. Required: input3 is granted, then input0, then input3.
- Hysteresis:
  - Thresholds 5/2; raise out_count[2] to 5 in cycle N. Required: pause=1 in N+1, and the grant from N still pushes in N+1.
  - Lower out_count[2] to 3. Required: pause stays 1.
  - Lower it to 2. Required: pause=0 on the next cycle and pops resume.
- Threshold zero: umbral_superior=0 while ACTIVE. Required: pause=1 after one cycle and no pops.
- State exit and async reset:
  - Drop State to IDLE mid-stream. Required: no pop that cycle, and the final push still occurs.
  - Assert reset between clock edges. Required: push, data_out and pause clear immediately.
